// File: rtl/slv_guard_rst_ctrl.sv
// Staged recovery controller behind the slave guard: interrupt first, then
// isolate/reset/settle the guarded slave if software does not acknowledge.
module slv_guard_rst_ctrl #(
    parameter int unsigned AckTimeout    = 1024,
    parameter int unsigned RstHoldCycles = 16,
    parameter int unsigned SettleCycles  = 8,
    parameter int unsigned CntWidth      = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       irq_i,
    input  logic       rst_req_i,
    input  logic       sw_ack_i,
    input  logic       sw_rst_en_i,
    output logic       irq_o,
    output logic       isolate_o,
    output logic       slv_rst_no,
    output logic       guard_clr_o,
    output logic       busy_o,
    output logic [2:0] state_o,
    output logic [7:0] rst_cnt_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PENDING = 3'd1,
        ISOLATE = 3'd2,
        RESET   = 3'd3,
        SETTLE  = 3'd4,
        CLEAR   = 3'd5
    } state_e;

    state_e              state_q;
    state_e              state_d;
    logic [CntWidth-1:0] timer_q;
    logic                irq_q;
    logic                guard_event;

    assign guard_event = (irq_i & ~irq_q) | rst_req_i;
    assign state_o     = state_q;

    // The timer counts cycles spent in the current state, starting at 0.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rst_req_i && sw_rst_en_i) begin
                    state_d = ISOLATE;
                end else if (guard_event) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (sw_ack_i) begin
                    state_d = CLEAR;
                end else if ((rst_req_i || timer_q == CntWidth'(AckTimeout - 1)) && sw_rst_en_i) begin
                    state_d = ISOLATE;
                end
            end
            ISOLATE: begin
                if (timer_q == CntWidth'(1)) begin
                    state_d = RESET;
                end
            end
            RESET: begin
                if (timer_q == CntWidth'(RstHoldCycles - 1)) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (timer_q == CntWidth'(SettleCycles - 1)) begin
                    state_d = CLEAR;
                end
            end
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change cleanly with it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            irq_q       <= 1'b0;
            irq_o       <= 1'b0;
            isolate_o   <= 1'b0;
            slv_rst_no  <= 1'b1;
            guard_clr_o <= 1'b0;
            busy_o      <= 1'b0;
            rst_cnt_o   <= 8'd0;
        end else begin
            irq_q   <= irq_i;
            state_q <= state_d;
            if (state_d != state_q) begin
                timer_q <= '0;
            end else if (timer_q != {CntWidth{1'b1}}) begin
                timer_q <= timer_q + CntWidth'(1);
            end
            if (state_d == RESET && state_q != RESET && rst_cnt_o != 8'hFF) begin
                rst_cnt_o <= rst_cnt_o + 8'd1;
            end
            irq_o       <= (state_d == PENDING) || (state_d == ISOLATE) ||
                           (state_d == RESET)   || (state_d == SETTLE);
            isolate_o   <= (state_d == ISOLATE) || (state_d == RESET) || (state_d == SETTLE);
            slv_rst_no  <= (state_d != RESET);
            guard_clr_o <= (state_d == CLEAR);
            busy_o      <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// Directed bench for slv_guard_rst_ctrl with AckTimeout=8, RstHoldCycles=4,
// SettleCycles=2; checks sampled 1 time unit after each rising edge.
module tb_slv_guard_rst_ctrl;

    localparam int unsigned AckTimeout    = 8;
    localparam int unsigned RstHoldCycles = 4;
    localparam int unsigned SettleCycles  = 2;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PENDING = 3'd1;
    localparam logic [2:0] S_ISOLATE = 3'd2;
    localparam logic [2:0] S_RESET   = 3'd3;
    localparam logic [2:0] S_SETTLE  = 3'd4;
    localparam logic [2:0] S_CLEAR   = 3'd5;

    logic       clk;
    logic       rst;
    logic       irq_in;
    logic       rst_req;
    logic       sw_ack;
    logic       sw_rst_en;
    logic       irq_out;
    logic       isolate;
    logic       slv_rst_n;
    logic       guard_clr;
    logic       busy;
    logic [2:0] state;
    logic [7:0] rst_cnt;

    int num_checks = 0;
    int num_fails  = 0;

    slv_guard_rst_ctrl #(
        .AckTimeout   (AckTimeout),
        .RstHoldCycles(RstHoldCycles),
        .SettleCycles (SettleCycles),
        .CntWidth     (16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .irq_i      (irq_in),
        .rst_req_i  (rst_req),
        .sw_ack_i   (sw_ack),
        .sw_rst_en_i(sw_rst_en),
        .irq_o      (irq_out),
        .isolate_o  (isolate),
        .slv_rst_no (slv_rst_n),
        .guard_clr_o(guard_clr),
        .busy_o     (busy),
        .state_o    (state),
        .rst_cnt_o  (rst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic irq_v, input logic rst_req_v, input logic ack_v, input logic en_v);
        irq_in    = irq_v;
        rst_req   = rst_req_v;
        sw_ack    = ack_v;
        sw_rst_en = en_v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks every output for n consecutive cycles in the expected state.
    task automatic expectState(input string tag, input logic [2:0] st, input int n);
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_state"}, 32'(state), 32'(st));
            checkOutput({tag, "_irq"}, 32'(irq_out),
                        32'(st == S_PENDING || st == S_ISOLATE || st == S_RESET || st == S_SETTLE));
            checkOutput({tag, "_isolate"}, 32'(isolate),
                        32'(st == S_ISOLATE || st == S_RESET || st == S_SETTLE));
            checkOutput({tag, "_slv_rst_n"}, 32'(slv_rst_n), 32'(st != S_RESET));
            checkOutput({tag, "_guard_clr"}, 32'(guard_clr), 32'(st == S_CLEAR));
            checkOutput({tag, "_busy"}, 32'(busy), 32'(st != S_IDLE));
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        expectState("reset", S_IDLE, 1);
        checkOutput("reset_cnt", 32'(rst_cnt), 32'd0);
        #3 rst = 1'b0;
        tick();
        expectState("idle0", S_IDLE, 3);

        // Scenario 1: ack path, irq_i left high to show no retrigger
        $display("[TB] scenario 1: acknowledged interrupt");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        expectState("s1_pend", S_PENDING, 2);
        checkOutput("s1_pend3_state", 32'(state), 32'(S_PENDING));
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        expectState("s1_clear", S_CLEAR, 1);
        expectState("s1_idle", S_IDLE, 4);
        checkOutput("s1_cnt", 32'(rst_cnt), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Scenario 2: timeout escalates to a full reset sequence
        $display("[TB] scenario 2: autonomous reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        expectState("s2_pend", S_PENDING, 8);
        expectState("s2_iso", S_ISOLATE, 2);
        expectState("s2_rst", S_RESET, 1);
        checkOutput("s2_cnt_in_reset", 32'(rst_cnt), 32'd1);
        expectState("s2_rst", S_RESET, 3);
        expectState("s2_settle", S_SETTLE, 2);
        expectState("s2_clear", S_CLEAR, 1);
        expectState("s2_idle", S_IDLE, 2);
        checkOutput("s2_cnt", 32'(rst_cnt), 32'd1);

        // Scenario 3: reset disabled, stays pending until acknowledged
        $display("[TB] scenario 3: reset disabled");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        expectState("s3_pend", S_PENDING, 100);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        expectState("s3_clear", S_CLEAR, 1);
        expectState("s3_idle", S_IDLE, 1);
        checkOutput("s3_cnt", 32'(rst_cnt), 32'd1);

        // Scenario 4: reset request skips PENDING
        $display("[TB] scenario 4: direct reset request");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        expectState("s4_iso", S_ISOLATE, 2);
        expectState("s4_rst", S_RESET, 4);
        expectState("s4_settle", S_SETTLE, 2);
        expectState("s4_clear", S_CLEAR, 1);
        expectState("s4_idle", S_IDLE, 1);
        checkOutput("s4_cnt", 32'(rst_cnt), 32'd2);

        // Scenario 5: ack on the last pending cycle beats the timeout
        $display("[TB] scenario 5: ack at timeout boundary");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        expectState("s5_pend", S_PENDING, 7);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("s5_last_pend", 32'(state), 32'(S_PENDING));
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        expectState("s5_clear", S_CLEAR, 1);
        expectState("s5_idle", S_IDLE, 2);
        checkOutput("s5_cnt", 32'(rst_cnt), 32'd2);

        // Scenario 6: asynchronous reset in the middle of RESET
        $display("[TB] scenario 6: async reset mid-RESET");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        expectState("s6_pend", S_PENDING, 8);
        expectState("s6_iso", S_ISOLATE, 2);
        expectState("s6_rst", S_RESET, 1);
        checkOutput("s6_rst2_slv", 32'(slv_rst_n), 32'd0);
        checkOutput("s6_cnt_pre", 32'(rst_cnt), 32'd3);
        rst = 1'b1;
        #1;
        checkOutput("s6_async_slv", 32'(slv_rst_n), 32'd1);
        checkOutput("s6_async_iso", 32'(isolate), 32'd0);
        checkOutput("s6_async_state", 32'(state), 32'(S_IDLE));
        checkOutput("s6_async_cnt", 32'(rst_cnt), 32'd0);
        #1 rst = 1'b0;
        tick();
        expectState("s6_idle", S_IDLE, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        expectState("s6_repend", S_PENDING, 2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        expectState("s6_clear", S_CLEAR, 1);
        expectState("s6_idle2", S_IDLE, 1);
        checkOutput("s6_cnt_end", 32'(rst_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
